burst_ram_arbiter: RTL and testbench



---
 rtl/burst_ram_pkg.sv | 21 ++
 rtl/burst_ram_cmd_spacer.sv | 32 +++
 rtl/burst_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// Shared definitions for every master that talks to the burst-RAM (PSRAM) command port.
package burst_ram_pkg;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    localparam int BURST_BEATS = 4;
    localparam int DEFAULT_COMMAND_DELAY_INTERVAL = 13;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage

// File: rtl/burst_ram_cmd_spacer.sv
// Minimum command spacing timer for a burst-RAM master.
// Loading starts a countdown from DELAY; 'zero' says a new command may be issued.
module burst_ram_cmd_spacer
    import burst_ram_pkg::*;
#(
    parameter int DELAY = DEFAULT_COMMAND_DELAY_INTERVAL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int CNT_W = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(DELAY);

    logic [CNT_W-1:0] count;

    // Reload on every issued command, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/burst_ram_arbiter.sv
// Two-client round-robin arbiter sharing the burst-RAM command/data port between the
// instruction cache (A) and data cache (B). Each burst is granted atomically and the
// PSRAM command spacing is enforced here so the clients need not track it.
module burst_ram_arbiter
    import burst_ram_pkg::*;
#(
    parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
    parameter int COMMAND_DELAY_INTERVAL   = DEFAULT_COMMAND_DELAY_INTERVAL
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                a_cmd,
    input  logic                                a_cmd_en,
    output logic                                a_cmd_ready,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] a_addr,
    input  logic [63:0]                         a_wr_data,
    input  logic [7:0]                          a_data_mask,
    output logic [63:0]                         a_rd_data,
    output logic                                a_rd_data_valid,

    input  logic                                b_cmd,
    input  logic                                b_cmd_en,
    output logic                                b_cmd_ready,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] b_addr,
    input  logic [63:0]                         b_wr_data,
    input  logic [7:0]                          b_data_mask,
    output logic [63:0]                         b_rd_data,
    output logic                                b_rd_data_valid,

    output logic                                br_cmd,
    output logic                                br_cmd_en,
    output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                         br_wr_data,
    output logic [7:0]                          br_data_mask,
    input  logic [63:0]                         br_rd_data,
    input  logic                                br_rd_data_valid
);

    localparam int BEAT_W = (BURST_BEATS < 2) ? 1 : $clog2(BURST_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

    arb_state_t state;
    arb_state_t next_state;

    // last_owner doubles as the current owner while a burst is in flight.
    owner_t last_owner;
    owner_t sel_owner;

    logic              grant;
    logic              grant_cmd;
    logic              spacer_zero;
    logic [BEAT_W-1:0] beat_cnt;

    logic                                sel_cmd;
    logic [BURST_RAM_DEPTH_BITWIDTH-1:0] sel_addr;
    logic [63:0]                         sel_wr_data;
    logic [7:0]                          sel_data_mask;

    burst_ram_cmd_spacer #(
        .DELAY (COMMAND_DELAY_INTERVAL)
    ) u_spacer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (grant),
        .zero  (spacer_zero)
    );

    assign a_rd_data = br_rd_data;
    assign b_rd_data = br_rd_data;

    assign sel_cmd       = (sel_owner == OWNER_A) ? a_cmd       : b_cmd;
    assign sel_addr      = (sel_owner == OWNER_A) ? a_addr      : b_addr;
    assign sel_wr_data   = (sel_owner == OWNER_A) ? a_wr_data   : b_wr_data;
    assign sel_data_mask = (sel_owner == OWNER_A) ? a_data_mask : b_data_mask;

    // Arbiter state register; an in-flight burst is abandoned on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pick a winner in IDLE, steer read-valid to the owner and decide when the burst ends.
    always_comb begin
        next_state      = state;
        grant           = 1'b0;
        grant_cmd       = BR_CMD_READ;
        sel_owner       = last_owner;
        a_cmd_ready     = 1'b0;
        b_cmd_ready     = 1'b0;
        a_rd_data_valid = 1'b0;
        b_rd_data_valid = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (rst_n && spacer_zero && (a_cmd_en || b_cmd_en)) begin
                    grant = 1'b1;
                    if (a_cmd_en && b_cmd_en) begin
                        sel_owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
                    end else if (a_cmd_en) begin
                        sel_owner = OWNER_A;
                    end else begin
                        sel_owner = OWNER_B;
                    end
                    a_cmd_ready = (sel_owner == OWNER_A);
                    b_cmd_ready = (sel_owner == OWNER_B);
                    grant_cmd   = (sel_owner == OWNER_A) ? a_cmd : b_cmd;
                    next_state  = (grant_cmd == BR_CMD_WRITE) ? ARB_WRITE : ARB_READ;
                end
            end
            ARB_READ: begin
                if (last_owner == OWNER_A) begin
                    a_rd_data_valid = br_rd_data_valid;
                end else begin
                    b_rd_data_valid = br_rd_data_valid;
                end
                if (br_rd_data_valid && (beat_cnt == LAST_BEAT)) begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_WRITE: begin
                if (beat_cnt == LAST_BEAT) begin
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Register the granted command and each write beat towards the RAM; track beats moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cmd       <= BR_CMD_READ;
            br_cmd_en    <= 1'b0;
            br_addr      <= '0;
            br_wr_data   <= '0;
            br_data_mask <= '0;
            last_owner   <= OWNER_B;
            beat_cnt     <= '0;
        end else begin
            br_cmd_en <= grant;
            if (grant) begin
                br_cmd       <= sel_cmd;
                br_addr      <= sel_addr;
                br_wr_data   <= sel_wr_data;
                br_data_mask <= sel_data_mask;
                last_owner   <= sel_owner;
                beat_cnt     <= (sel_cmd == BR_CMD_WRITE) ? BEAT_W'(1) : '0;
            end else if (state == ARB_WRITE) begin
                br_wr_data   <= sel_wr_data;
                br_data_mask <= sel_data_mask;
                beat_cnt     <= beat_cnt + 1'b1;
            end else if ((state == ARB_READ) && br_rd_data_valid) begin
                beat_cnt     <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-number based model of the arbitration rules.
module tb_burst_ram_arbiter;

    localparam int AW    = 21;
    localparam int CDI   = 13;
    localparam int BEATS = 4;
    localparam int HIST  = 8192;

    logic clk;
    logic rst_n;
    logic a_cmd, a_cmd_en, a_cmd_ready, a_rd_data_valid;
    logic [AW-1:0] a_addr;
    logic [63:0] a_wr_data, a_rd_data;
    logic [7:0] a_data_mask;
    logic b_cmd, b_cmd_en, b_cmd_ready, b_rd_data_valid;
    logic [AW-1:0] b_addr;
    logic [63:0] b_wr_data, b_rd_data;
    logic [7:0] b_data_mask;
    logic br_cmd, br_cmd_en, br_rd_data_valid;
    logic [AW-1:0] br_addr;
    logic [63:0] br_wr_data, br_rd_data;
    logic [7:0] br_data_mask;

    burst_ram_arbiter #(
        .BURST_RAM_DEPTH_BITWIDTH (AW),
        .COMMAND_DELAY_INTERVAL   (CDI)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a_cmd            (a_cmd),
        .a_cmd_en         (a_cmd_en),
        .a_cmd_ready      (a_cmd_ready),
        .a_addr           (a_addr),
        .a_wr_data        (a_wr_data),
        .a_data_mask      (a_data_mask),
        .a_rd_data        (a_rd_data),
        .a_rd_data_valid  (a_rd_data_valid),
        .b_cmd            (b_cmd),
        .b_cmd_en         (b_cmd_en),
        .b_cmd_ready      (b_cmd_ready),
        .b_addr           (b_addr),
        .b_wr_data        (b_wr_data),
        .b_data_mask      (b_data_mask),
        .b_rd_data        (b_rd_data),
        .b_rd_data_valid  (b_rd_data_valid),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad = 0;

    logic          req [2];
    logic          req_cmd [2];
    logic [AW-1:0] req_addr [2];
    logic [63:0]   wd [2];
    logic [7:0]    wm [2];
    logic          ram_valid;
    logic [63:0]   ram_data;

    logic [63:0] hist_wd [2][HIST];
    logic [7:0]  hist_wm [2][HIST];

    typedef struct {
        int at;
        int src;
        int own;
    } beat_t;
    beat_t beatq [$];

    int cyc = 0;
    int ok_cycle = 0;
    int wr_free = 0;
    int grant_cyc = -100;
    bit rd_active = 0;
    int rd_beats = 0;
    int rd_owner = 0;
    int last_owner = 1;
    bit in_reset = 1;
    logic          e_cmd;
    logic [AW-1:0] e_addr;

    int cmd_log [$];
    int grant_log [$];
    int vcnt_a = 0;
    int vcnt_b = 0;
    logic          obs_a_ready, obs_b_ready, obs_br_cmd_en, obs_br_cmd;
    logic [AW-1:0] obs_br_addr;
    logic [63:0]   obs_br_wr_data;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus();
        a_cmd_en         = req[0];
        a_cmd            = req_cmd[0];
        a_addr           = req_addr[0];
        a_wr_data        = wd[0];
        a_data_mask      = wm[0];
        b_cmd_en         = req[1];
        b_cmd            = req_cmd[1];
        b_addr           = req_addr[1];
        b_wr_data        = wd[1];
        b_data_mask      = wm[1];
        br_rd_data_valid = ram_valid;
        br_rd_data       = ram_data;
    endtask

    function automatic bit modelIdle();
        return (cyc >= ok_cycle) && !rd_active && (cyc >= wr_free);
    endfunction

    task automatic runCycle();
        bit g;
        int w;
        logic ea, eb, eva, evb, ecmd_en;
        beat_t bt;
        applyStimulus();
        @(negedge clk);
        hist_wd[0][cyc % HIST] = wd[0];
        hist_wd[1][cyc % HIST] = wd[1];
        hist_wm[0][cyc % HIST] = wm[0];
        hist_wm[1][cyc % HIST] = wm[1];
        g = 0; w = 0; ea = 0; eb = 0; eva = 0; evb = 0;
        if (!in_reset) begin
            if (modelIdle() && (req[0] || req[1])) begin
                g = 1;
                if (req[0] && req[1]) w = 1 - last_owner;
                else w = req[0] ? 0 : 1;
                ea = (w == 0);
                eb = (w == 1);
            end
            eva = rd_active && ram_valid && (rd_owner == 0);
            evb = rd_active && ram_valid && (rd_owner == 1);
        end
        ecmd_en = !in_reset && (cyc == grant_cyc + 1);
        checkOutput("a_cmd_ready", a_cmd_ready, ea);
        checkOutput("b_cmd_ready", b_cmd_ready, eb);
        checkOutput("a_rd_valid", a_rd_data_valid, eva);
        checkOutput("b_rd_valid", b_rd_data_valid, evb);
        checkOutput("a_rd_data", a_rd_data, ram_data);
        checkOutput("b_rd_data", b_rd_data, ram_data);
        checkOutput("br_cmd_en", br_cmd_en, ecmd_en);
        if (ecmd_en) begin
            checkOutput("br_cmd", br_cmd, e_cmd);
            checkOutput("br_addr", br_addr, e_addr);
        end
        while (beatq.size() > 0 && beatq[0].at == cyc) begin
            bt = beatq.pop_front();
            checkOutput("br_wr_data", br_wr_data, hist_wd[bt.own][bt.src % HIST]);
            checkOutput("br_data_mask", br_data_mask, hist_wm[bt.own][bt.src % HIST]);
        end
        if (in_reset) begin
            checkOutput("rst_br_addr", br_addr, 0);
            checkOutput("rst_br_wr_data", br_wr_data, 0);
        end
        obs_a_ready    = a_cmd_ready;
        obs_b_ready    = b_cmd_ready;
        obs_br_cmd_en  = br_cmd_en;
        obs_br_cmd     = br_cmd;
        obs_br_addr    = br_addr;
        obs_br_wr_data = br_wr_data;
        if (br_cmd_en === 1'b1) cmd_log.push_back(cyc);
        if (a_cmd_ready === 1'b1 && a_cmd_en) grant_log.push_back(0);
        if (b_cmd_ready === 1'b1 && b_cmd_en) grant_log.push_back(1);
        if (a_rd_data_valid === 1'b1) vcnt_a++;
        if (b_rd_data_valid === 1'b1) vcnt_b++;
        if (!in_reset) begin
            if (rd_active && ram_valid) begin
                rd_beats++;
                if (rd_beats == BEATS) rd_active = 0;
            end
            if (g) begin
                grant_cyc  = cyc;
                ok_cycle   = cyc + CDI + 1;
                last_owner = w;
                e_cmd      = req_cmd[w];
                e_addr     = req_addr[w];
                beatq.push_back('{at: cyc + 1, src: cyc, own: w});
                if (req_cmd[w]) begin
                    for (int k = 1; k < BEATS; k++)
                        beatq.push_back('{at: cyc + 1 + k, src: cyc + k, own: w});
                    wr_free = cyc + BEATS;
                end else begin
                    rd_active = 1;
                    rd_beats  = 0;
                    rd_owner  = w;
                end
                req[w] = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        in_reset = 1;
        beatq.delete();
        grant_cyc = -100;
        rd_active = 0;
        #1;
        checkOutput("rst_a_ready", a_cmd_ready, 0);
        checkOutput("rst_b_ready", b_cmd_ready, 0);
        checkOutput("rst_a_valid", a_rd_data_valid, 0);
        checkOutput("rst_b_valid", b_rd_data_valid, 0);
        checkOutput("rst_br_cmd_en", br_cmd_en, 0);
        checkOutput("rst_br_cmd", br_cmd, 0);
        checkOutput("rst_br_addr_now", br_addr, 0);
        checkOutput("rst_br_wr_data_now", br_wr_data, 0);
        checkOutput("rst_br_mask_now", br_data_mask, 0);
        for (int i = 0; i < n; i++) runCycle();
        rst_n = 1'b1;
        in_reset = 0;
        ok_cycle = cyc;
        wr_free = 0;
        last_owner = 1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        ram_valid = 1'b1;
        while (!modelIdle() && n < 100) begin
            ram_data = {$urandom, $urandom};
            runCycle();
            n++;
        end
        ram_valid = 1'b0;
        if (n >= 100) checkOutput("wait_idle_timeout", 0, 1);
    endtask

    task automatic runUntilCmds(input int cnt);
        int start;
        int n;
        start = cmd_log.size();
        n = 0;
        ram_valid = 1'b1;
        while (cmd_log.size() < start + cnt && n < 200) begin
            ram_data = {$urandom, $urandom};
            runCycle();
            n++;
        end
        ram_valid = 1'b0;
        if (n >= 200) checkOutput("cmd_wait_timeout", 0, 1);
    endtask

    logic [63:0] t1_beats [4];
    int g0;
    int n_loop;

    initial begin
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req[c] = 0; req_cmd[c] = 0; req_addr[c] = '0; wd[c] = '0; wm[c] = '0;
        end
        ram_valid = 0;
        ram_data = '0;
        applyStimulus();
        #1;
        doReset(3);

        // A read alone
        t1_beats[0] = 64'h1111_1111_1111_1111;
        t1_beats[1] = 64'h2222_2222_2222_2222;
        t1_beats[2] = 64'h3333_3333_3333_3333;
        t1_beats[3] = 64'h4444_4444_4444_4444;
        runCycle();
        runCycle();
        req[0] = 1; req_cmd[0] = 0; req_addr[0] = 21'h00010;
        runCycle();
        checkOutput("t1_a_granted", obs_a_ready, 1);
        runCycle();
        checkOutput("t1_br_cmd_en", obs_br_cmd_en, 1);
        checkOutput("t1_br_cmd", obs_br_cmd, 0);
        checkOutput("t1_br_addr", obs_br_addr, 21'h00010);
        vcnt_a = 0; vcnt_b = 0;
        for (int k = 0; k < 4; k++) begin
            ram_valid = 1; ram_data = t1_beats[k];
            runCycle();
        end
        ram_valid = 0;
        checkOutput("t1_a_beats", vcnt_a, 4);
        checkOutput("t1_b_beats", vcnt_b, 0);
        waitIdle();

        // Simultaneous reads after reset: A first, B 14 cycles later, next tie to A
        doReset(2);
        req[0] = 1; req_cmd[0] = 0; req_addr[0] = 21'h00100;
        req[1] = 1; req_cmd[1] = 0; req_addr[1] = 21'h00200;
        runCycle();
        checkOutput("t2_a_first", obs_a_ready, 1);
        checkOutput("t2_b_waits", obs_b_ready, 0);
        runUntilCmds(2);
        checkOutput("t2_spacing", cmd_log[cmd_log.size() - 1] - cmd_log[cmd_log.size() - 2], CDI + 1);
        waitIdle();
        req[0] = 1; req_cmd[0] = 0; req_addr[0] = 21'h00300;
        req[1] = 1; req_cmd[1] = 0; req_addr[1] = 21'h00400;
        runCycle();
        checkOutput("t2_tie_to_a", obs_a_ready, 1);
        req[1] = 0;
        waitIdle();

        // B write, beats A0..A3, mask FF
        req[1] = 1; req_cmd[1] = 1; req_addr[1] = 21'h1ABCD;
        wd[1] = 64'hA0; wm[1] = 8'hFF;
        runCycle();
        checkOutput("t3_b_granted", obs_b_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) wd[1] = 64'hA0 + 64'(k);
            else wd[1] = 64'h0;
            runCycle();
            checkOutput("t3_wr_beat", obs_br_wr_data, 64'hA0 + 64'(k - 1));
            if (k == 1) checkOutput("t3_br_cmd", obs_br_cmd, 1);
        end
        waitIdle();

        // A holds cmd_en, B requests: grants alternate A, B, A
        g0 = grant_log.size();
        n_loop = 0;
        ram_valid = 1;
        while (grant_log.size() < g0 + 3 && n_loop < 200) begin
            req[0] = 1; req_cmd[0] = 0; req_addr[0] = 21'($urandom);
            req[1] = 1; req_cmd[1] = 0; req_addr[1] = 21'($urandom);
            ram_data = {$urandom, $urandom};
            runCycle();
            n_loop++;
        end
        req[0] = 0; req[1] = 0;
        if (n_loop >= 200) begin
            checkOutput("t4_timeout", 0, 1);
        end else begin
            checkOutput("t4_first_a", grant_log[g0], 0);
            checkOutput("t4_second_b", grant_log[g0 + 1], 1);
            checkOutput("t4_third_a", grant_log[g0 + 2], 0);
        end
        runUntilCmds(1);
        for (int i = cmd_log.size() - 2; i < cmd_log.size(); i++)
            checkOutput("t4_spacing_ge14", (cmd_log[i] - cmd_log[i - 1]) >= CDI + 1, 1);
        waitIdle();

        // Reset after 2 of 4 read beats
        req[0] = 1; req_cmd[0] = 0; req_addr[0] = 21'h0F0F0;
        runCycle();
        checkOutput("t5_a_granted", obs_a_ready, 1);
        vcnt_a = 0;
        for (int k = 0; k < 2; k++) begin
            ram_valid = 1; ram_data = {$urandom, $urandom};
            runCycle();
        end
        checkOutput("t5_two_beats", vcnt_a, 2);
        vcnt_a = 0; vcnt_b = 0;
        doReset(1);
        ram_data = {$urandom, $urandom};
        runCycle();
        ram_valid = 0;
        checkOutput("t5_trailing_a", vcnt_a, 0);
        checkOutput("t5_trailing_b", vcnt_b, 0);
        req[0] = 1; req_cmd[0] = 0; req_addr[0] = 21'h00042;
        runCycle();
        checkOutput("t5_regrant", obs_a_ready, 1);
        waitIdle();

        // Stray RAM valid in IDLE is dropped and does not disturb the next grant
        vcnt_a = 0; vcnt_b = 0;
        ram_valid = 1; ram_data = 64'hDEAD_BEEF_0000_0001;
        runCycle();
        ram_valid = 0;
        checkOutput("t6_stray_a", vcnt_a, 0);
        checkOutput("t6_stray_b", vcnt_b, 0);
        req[1] = 1; req_cmd[1] = 0; req_addr[1] = 21'h00077;
        runCycle();
        checkOutput("t6_grant", obs_b_ready, 1);
        waitIdle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!req[c]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req[c] = 1;
                        req_cmd[c] = 1'($urandom_range(0, 1));
                        req_addr[c] = 21'($urandom);
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req[c] = 0;
                end
                wd[c] = {$urandom, $urandom};
                wm[c] = 8'($urandom);
            end
            ram_valid = 1'($urandom_range(0, 1));
            ram_data = {$urandom, $urandom};
            if (i == 700) doReset(2);
            runCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
